// File: rtl/mem_access_ctrl_if.sv
// Data-side SRAM-like bus between the MEM-stage access controller (master)
// and the bus bridge (slave): one request channel, one response channel.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              data_req_o;
  logic              data_wr_o;
  logic [1:0]        data_size_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [3:0]        data_wstrb_o;
  logic [31:0]       data_wdata_o;
  logic              data_addr_ok_i;
  logic              data_data_ok_i;
  logic [31:0]       data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a single-outstanding SRAM-like data port.
// Builds lane-aligned strobes/data for SB/SH/SW/SC/SWL/SWR, stalls the pipeline
// until the bus transaction finishes and survives flushes mid-transaction.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [3:0]        store_type_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  mem_access_ctrl_if.master bus
);

  localparam logic [3:0] STORE_SB  = 4'd0;
  localparam logic [3:0] STORE_SH  = 4'd1;
  localparam logic [3:0] STORE_SW  = 4'd2;
  localparam logic [3:0] STORE_SC  = 4'd3;
  localparam logic [3:0] STORE_SWL = 4'd4;
  localparam logic [3:0] STORE_SWR = 4'd5;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t            state_reg, state_next;
  logic              wr_reg;
  logic [1:0]        size_reg, size_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]        wstrb_reg, wstrb_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       rdata_reg;
  logic              capture, rdata_load;
  logic [1:0]        lane;

  assign lane = mem_addr_i[1:0];

  // Decode the incoming access into bus size, address, strobes and aligned data.
  always_comb begin
    size_next  = 2'd2;
    addr_next  = {mem_addr_i[ADDR_W-1:2], 2'b00};
    wstrb_next = 4'b0000;
    wdata_next = 32'h0;
    if (mem_we_i) begin
      case (store_type_i)
        STORE_SB: begin
          size_next  = 2'd0;
          addr_next  = mem_addr_i;
          wstrb_next = 4'b0001 << lane;
          wdata_next = {24'h0, mem_wdata_i[7:0]} << {lane, 3'b000};
        end
        STORE_SH: begin
          size_next  = 2'd1;
          addr_next  = mem_addr_i;
          wstrb_next = lane[1] ? 4'b1100 : 4'b0011;
          wdata_next = lane[1] ? {mem_wdata_i[15:0], 16'h0} : {16'h0, mem_wdata_i[15:0]};
        end
        STORE_SWL: begin
          wstrb_next = 4'b1111 >> (2'd3 - lane);
          wdata_next = mem_wdata_i >> {(2'd3 - lane), 3'b000};
        end
        STORE_SWR: begin
          wstrb_next = 4'b1111 << lane;
          wdata_next = mem_wdata_i << {lane, 3'b000};
        end
        STORE_SW, STORE_SC: begin
          wstrb_next = 4'b1111;
          wdata_next = mem_wdata_i;
        end
        default: begin
          wstrb_next = 4'b1111;
          wdata_next = mem_wdata_i;
        end
      endcase
    end
  end

  // Next-state and handshake/stall outputs; a flush after acceptance must still drain data_ok.
  always_comb begin
    state_next    = state_reg;
    stall_o       = 1'b0;
    bus.data_req_o = 1'b0;
    capture       = 1'b0;
    rdata_load    = 1'b0;
    rdata_valid_o = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_en_i && !flush_i) begin
          capture    = 1'b1;
          stall_o    = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        stall_o        = 1'b1;
        bus.data_req_o = 1'b1;
        if (flush_i) begin
          if (bus.data_addr_ok_i && !bus.data_data_ok_i) state_next = S_CANCEL;
          else                                             state_next = S_IDLE;
        end else if (bus.data_addr_ok_i) begin
          if (bus.data_data_ok_i) begin
            rdata_load = !wr_reg;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus.data_data_ok_i) begin
          if (flush_i) begin
            state_next = S_IDLE;
          end else begin
            rdata_load = !wr_reg;
            state_next = S_DONE;
          end
        end else if (flush_i) begin
          state_next = S_CANCEL;
        end
      end
      S_DONE: begin
        rdata_valid_o = !wr_reg && !flush_i;
        state_next    = S_IDLE;
      end
      S_CANCEL: begin
        stall_o = 1'b1;
        if (bus.data_data_ok_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Request registers hold the bus fields stable for the whole request phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= '0;
      wstrb_reg <= 4'b0000;
      wdata_reg <= 32'h0;
    end else if (capture) begin
      wr_reg    <= mem_we_i;
      size_reg  <= size_next;
      addr_reg  <= addr_next;
      wstrb_reg <= wstrb_next;
      wdata_reg <= wdata_next;
    end
  end

  // Load data is latched only for a live (non-cancelled) load response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata_reg <= 32'h0;
    else if (rdata_load) rdata_reg <= bus.data_rdata_i;
  end

  assign rdata_o          = rdata_reg;
  assign bus.data_wr_o    = wr_reg;
  assign bus.data_size_o  = size_reg;
  assign bus.data_addr_o  = addr_reg;
  assign bus.data_wstrb_o = wstrb_reg;
  assign bus.data_wdata_o = wdata_reg;

endmodule
